// File: rtl/rotate_seq_16bit.sv
// rotate_seq_16bit: multi-cycle sequential rotator with valid/ready handshakes.
//
// A request (a, amt, choice) is taken on start_valid && start_ready. The
// operand is then rotated one bit per clock until amt positions have been
// covered. The result is presented on y/y_valid and held until y_ready.
// This gives a small-area alternative to a full barrel shifter.
//
// Optional build macro:
//   ROT_FAST_EN - while at least 4 positions remain, rotate by 4 per clock.
//                 The result is identical; latency drops to amt/4 + amt%4.
//
// Ports:
//   clk          in   rising-edge system clock
//   reset_n      in   asynchronous active-low reset
//   start_valid  in   request present on a/amt/choice
//   start_ready  out  block can accept a request (IDLE)
//   a            in   [WIDTH-1:0] operand
//   amt          in   [AMT_W-1:0] rotate distance, 0..WIDTH-1
//   choice       in   direction: 1 = rotate left, 0 = rotate right
//   y            out  [WIDTH-1:0] result register (valid while y_valid)
//   y_valid      out  result available (DONE)
//   y_ready      in   consumer takes result
//   busy         out  high in SHIFT or DONE
module rotate_seq_16bit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  input  logic             choice,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;

  // Single-position rotates; the bit leaving one end re-enters at the other.
  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] rotr1(input logic [WIDTH-1:0] x);
    return {x[0], x[WIDTH-1:1]};
  endfunction

`ifdef ROT_FAST_EN
  // Four-position rotates, only present in the fast build.
  function automatic logic [WIDTH-1:0] rotl4(input logic [WIDTH-1:0] x);
    return {x[WIDTH-5:0], x[WIDTH-1:WIDTH-4]};
  endfunction

  function automatic logic [WIDTH-1:0] rotr4(input logic [WIDTH-1:0] x);
    return {x[3:0], x[WIDTH-1:4]};
  endfunction

  // Take the wide step whenever at least four positions remain.
  logic fast_step_c;
  assign fast_step_c = (cnt_q >= AMT_W'(4));
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          data_d  = a;
          dir_d   = choice;
          cnt_d   = amt;
          // A zero-distance rotate has nothing to do and completes at once.
          state_d = (amt == '0) ? DONE : SHIFT;
        end
      end

      SHIFT: begin
`ifdef ROT_FAST_EN
        if (fast_step_c) begin
          data_d = dir_q ? rotl4(data_q) : rotr4(data_q);
          cnt_d  = cnt_q - AMT_W'(4);
        end else begin
          data_d = dir_q ? rotl1(data_q) : rotr1(data_q);
          cnt_d  = cnt_q - AMT_W'(1);
        end
`else
        data_d = dir_q ? rotl1(data_q) : rotr1(data_q);
        cnt_d  = cnt_q - AMT_W'(1);
`endif
        // This edge covers the last remaining positions.
        if (cnt_d == '0) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // Hold the result; the data register keeps its value into IDLE.
        if (y_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake flags come from the registered state only.
  assign start_ready = (state_q == IDLE);
  assign y_valid     = (state_q == DONE);
  assign busy        = (state_q == SHIFT) || (state_q == DONE);
  assign y           = data_q;

endmodule

// File: tb/tb_rotate_seq_16bit.sv
module tb_rotate_seq_16bit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        choice = 1'b0;
  logic        y_ready = 1'b0;
  logic [15:0] a = 16'h0;
  logic [3:0]  amt = 4'h0;
  logic        start_ready;
  logic        y_valid;
  logic        busy;
  logic [15:0] y;

  typedef struct {
    logic [15:0] y;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  rotate_seq_16bit #(.WIDTH(16), .AMT_W(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .amt         (amt),
    .choice      (choice),
    .y           (y),
    .y_valid     (y_valid),
    .y_ready     (y_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference rotate built from a doubled operand.
  function automatic logic [15:0] ref_rot(input logic [15:0] v, input int n, input logic left);
    logic [31:0] t;
    t = {v, v};
    if (left) begin
      t = t << n;
      return t[31:16];
    end
    t = t >> n;
    return t[15:0];
  endfunction

  function automatic int exp_lat(input int n);
`ifdef ROT_FAST_EN
    return n / 4 + n % 4;
`else
    return n;
`endif
  endfunction

  // Drive one request from a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [15:0] av, input logic [3:0] n, input logic dir);
    exp_t e;
    a           = av;
    amt         = n;
    choice      = dir;
    start_valid = 1'b1;
    e.y   = ref_rot(av, int'(n), dir);
    e.lat = exp_lat(int'(n));
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    a           = 16'($urandom);
    amt         = 4'($urandom);
    choice      = 1'($urandom);
  endtask

  // Count edges after the accept edge until y_valid; bounded at 40.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!y_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (y !== 16'h0000) begin errors++; $display("FAIL reset_y got %h exp 0000", y); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid got %b exp 0", y_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready got %b exp 1", start_ready); end
  endtask

  task automatic test_basic;
    int   lat;
    exp_t e;
    y_ready = 1'b1;
    issue(16'hF3FF, 4'd4, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
    wait_valid(lat);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL basic_latency got %0d exp %0d", lat, e.lat); end
    checks++; if (y !== 16'h3FFF) begin errors++; $display("FAIL basic_y got %h exp 3fff", y); end
    @(negedge clk);
    checks++; if (y_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle got valid=%b ready=%b busy=%b exp 0 1 0", y_valid, start_ready, busy);
    end
    checks++; if (y !== 16'h3FFF) begin errors++; $display("FAIL basic_y_hold got %h exp 3fff", y); end
  endtask

  task automatic test_sweep;
    int          lat;
    exp_t        e;
    logic [15:0] av;
    y_ready = 1'b1;
    // Directed corners first.
    issue(16'h0001, 4'd3, 1'b0);
    wait_valid(lat);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL sweep_r3_latency got %0d exp %0d", lat, e.lat); end
    checks++; if (y !== 16'h2000) begin errors++; $display("FAIL sweep_r3_y got %h exp 2000", y); end
    @(negedge clk);
    issue(16'h0001, 4'd15, 1'b1);
    wait_valid(lat);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL sweep_l15_latency got %0d exp %0d", lat, e.lat); end
    checks++; if (y !== 16'h8000) begin errors++; $display("FAIL sweep_l15_y got %h exp 8000", y); end
    @(negedge clk);
    // Every distance in both directions.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 16; n++) begin
        av = (n % 3 == 0) ? 16'h8421 : 16'($urandom);
        issue(av, 4'(n), 1'(d));
        wait_valid(lat);
        if (sb.size() == 0) begin
          errors++; $display("FAIL sweep_scoreboard_empty dir=%0d amt=%0d", d, n);
        end else begin
          e = sb.pop_front();
          checks++; if (lat !== e.lat) begin errors++; $display("FAIL sweep_latency dir=%0d amt=%0d got %0d exp %0d", d, n, lat, e.lat); end
          checks++; if (y !== e.y) begin errors++; $display("FAIL sweep_y dir=%0d amt=%0d a=%h got %h exp %h", d, n, av, y, e.y); end
        end
        @(negedge clk);
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL sweep_return_idle dir=%0d amt=%0d got %b exp 1", d, n, start_ready); end
      end
    end
  endtask

  task automatic test_amt_zero;
    int   lat;
    exp_t e;
    y_ready = 1'b1;
    issue(16'hA5A5, 4'd0, 1'b1);
    checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL zero_valid_next_cycle got %b exp 1", y_valid); end
    wait_valid(lat);
    e = sb.pop_front();
    checks++; if (lat !== 0) begin errors++; $display("FAIL zero_latency got %0d exp 0", lat); end
    checks++; if (y !== 16'hA5A5) begin errors++; $display("FAIL zero_y got %h exp a5a5", y); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int   lat;
    exp_t e;
    y_ready = 1'b0;
    issue(16'h1357, 4'd6, 1'b1);
    wait_valid(lat);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL bp_latency got %0d exp %0d", lat, e.lat); end
    checks++; if (y !== e.y) begin errors++; $display("FAIL bp_y got %h exp %h", y, e.y); end
    // New request pending while the result is stalled.
    a           = 16'h1234;
    amt         = 4'd5;
    choice      = 1'b0;
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (y !== e.y || y_valid !== 1'b1 || start_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle=%0d got y=%h valid=%b ready=%b exp y=%h 1 0", i, y, y_valid, start_ready, e.y);
      end
    end
    y_ready = 1'b1;
    @(negedge clk);
    checks++; if (y_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release got valid=%b ready=%b busy=%b exp 0 1 0", y_valid, start_ready, busy);
    end
    checks++; if (y !== e.y) begin errors++; $display("FAIL bp_y_retained got %h exp %h", y, e.y); end
    // The held request is now accepted on the following edge.
    issue(16'h1234, 4'd5, 1'b0);
    wait_valid(lat);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL bp_second_latency got %0d exp %0d", lat, e.lat); end
    checks++; if (y !== 16'hA091) begin errors++; $display("FAIL bp_second_y got %h exp a091", y); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic saw;
    y_ready = 1'b1;
    issue(16'hBEEF, 4'd10, 1'b1);
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1 || y_valid !== 1'b0) begin errors++; $display("FAIL mid_shifting got busy=%b valid=%b exp 1 0", busy, y_valid); end
    reset_n = 1'b0;
    #1;
    checks++; if (y !== 16'h0000 || y_valid !== 1'b0 || start_ready !== 1'b1) begin
      errors++; $display("FAIL mid_async_reset got y=%h valid=%b ready=%b exp 0000 0 1", y, y_valid, start_ready);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (y_valid) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL mid_no_result got %b exp 0", saw); end
    checks++; if (y !== 16'h0000 || start_ready !== 1'b1) begin
      errors++; $display("FAIL mid_after_release got y=%h ready=%b exp 0000 1", y, start_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_amt_zero();
    test_backpressure();
    test_reset_mid();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d exp 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
